// File: rtl/pokemon_pkg.sv
// pokemon_pkg: shared direction/phase types and the 23-entry colour palette
package pokemon_pkg;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {REST1, M1, REST2, M2} anim_phase_t;
  localparam int PALETTE_N = 23;
  localparam logic [23:0] PALETTE [PALETTE_N] = '{
    24'h800080, 24'h101010, 24'hF83800, 24'hF0D0B0, 24'h503000, 24'hF8F8F8,
    24'hE8E8E8, 24'h3CBCFC, 24'h0058F8, 24'h00A800, 24'hB8F818, 24'h005800,
    24'hF8B800, 24'hAC7C00, 24'hD82800, 24'h7C7C7C, 24'hBCBCBC, 24'h6888FC,
    24'hF878F8, 24'h58D854, 24'hA4E4FC, 24'hFCE0A8, 24'h000088
  };
endpackage

// File: rtl/sprite_scroll_engine_if.sv
// sprite_scroll_engine_if: read bus to the map and sprite-sheet ROMs
interface sprite_scroll_engine_if;
  logic [16:0] map_addr;
  logic [16:0] spr_addr;
  logic [4:0] map_idx;
  logic [4:0] spr_idx;
  modport master(output map_addr, spr_addr, input map_idx, spr_idx);
  modport slave(input map_addr, spr_addr, output map_idx, spr_idx);
endinterface

// File: rtl/sprite_anim_fsm.sv
// sprite_anim_fsm: step divider, facing/walk-phase FSM and clamped camera
module sprite_anim_fsm
  import pokemon_pkg::*;
#(
  parameter int MAP_W = 320,
  parameter int MAP_H = 240,
  parameter int SCALE_LOG2 = 2,
  parameter int STEP_DIV = 1,
  parameter int CAM_X_RST = 100,
  parameter int CAM_Y_RST = 100
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic moving,
  input  logic [1:0] direction,
  output logic [10:0] cam_x,
  output logic [10:0] cam_y,
  output dir_t facing,
  output anim_phase_t phase,
  output logic blocked
);
  localparam int MAX_X = (MAP_W << SCALE_LOG2) - 640;
  localparam int MAX_Y = (MAP_H << SCALE_LOG2) - 480;
  logic [15:0] step_cnt;
  logic tick, at_edge;
  logic [10:0] cam_x_nxt, cam_y_nxt;
  dir_t dir;
  assign dir = dir_t'(direction);
  assign tick = frame_start && step_cnt == 16'(STEP_DIV - 1);
  // edge test and one-pixel move target in the current facing direction
  always_comb begin
    at_edge = facing == DIR_UP ? cam_y == 11'd0 :
              facing == DIR_RIGHT ? cam_x == 11'(MAX_X) :
              facing == DIR_DOWN ? cam_y == 11'(MAX_Y) : cam_x == 11'd0;
    cam_x_nxt = facing == DIR_RIGHT ? cam_x + 11'd1 : facing == DIR_LEFT ? cam_x - 11'd1 : cam_x;
    cam_y_nxt = facing == DIR_DOWN ? cam_y + 11'd1 : facing == DIR_UP ? cam_y - 11'd1 : cam_y;
  end
  // state only changes on a step tick so it is frame-stable
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cam_x <= 11'(CAM_X_RST);
      cam_y <= 11'(CAM_Y_RST);
      facing <= DIR_UP;
      phase <= REST1;
      step_cnt <= '0;
      blocked <= 1'b0;
    end else if (frame_start) begin
      step_cnt <= tick ? '0 : step_cnt + 16'd1;
      if (tick) begin
        blocked <= 1'b0;
        if (!moving) phase <= REST1;
        else if (dir != facing) begin
          facing <= dir;
          phase <= REST1;
        end else begin
          phase <= anim_phase_t'(phase + 2'd1);
          blocked <= at_edge;
          if (!at_edge) begin
            cam_x <= cam_x_nxt;
            cam_y <= cam_y_nxt;
          end
        end
      end
    end
  end
endmodule

// File: rtl/sprite_scroll_engine.sv
// sprite_scroll_engine: scrolled tile map with colour-keyed animated sprite, registered RGB
module sprite_scroll_engine
  import pokemon_pkg::*;
#(
  parameter int MAP_W = 320,
  parameter int MAP_H = 240,
  parameter int SCALE_LOG2 = 2,
  parameter int SPR_W = 19,
  parameter int SPR_H = 29,
  parameter int SHEET_W = 228,
  parameter int SPR_X0 = 311,
  parameter int SPR_Y0 = 340,
  parameter int STEP_DIV = 1,
  parameter int KEY_IDX = 6,
  parameter int CAM_X_RST = 100,
  parameter int CAM_Y_RST = 100
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic moving,
  input  logic [1:0] direction,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  sprite_scroll_engine_if.master rom,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic [10:0] cam_x,
  output logic [10:0] cam_y,
  output logic [1:0] facing,
  output logic blocked
);
  dir_t facing_q;
  anim_phase_t phase;
  logic in_box, in_box_q;
  logic [19:0] mx, my, sx, sy, col;
  logic [4:0] pix_idx;
  assign facing = facing_q;
  sprite_anim_fsm #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .SCALE_LOG2(SCALE_LOG2),
    .STEP_DIV(STEP_DIV), .CAM_X_RST(CAM_X_RST), .CAM_Y_RST(CAM_Y_RST)
  ) u_fsm (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .moving(moving),
    .direction(direction), .cam_x(cam_x), .cam_y(cam_y), .facing(facing_q),
    .phase(phase), .blocked(blocked)
  );
  // C0 address generation and C2 colour-key select
  always_comb begin
    mx = (20'(DrawX) + 20'(cam_x)) >> SCALE_LOG2;
    my = (20'(DrawY) + 20'(cam_y)) >> SCALE_LOG2;
    in_box = DrawX >= 10'(SPR_X0) && DrawX < 10'(SPR_X0 + SPR_W) &&
             DrawY >= 10'(SPR_Y0) && DrawY < 10'(SPR_Y0 + SPR_H);
    sx = 20'(DrawX) - 20'(SPR_X0);
    sy = 20'(DrawY) - 20'(SPR_Y0);
    col = 20'(((facing_q == DIR_DOWN ? 0 : facing_q == DIR_LEFT ? 3 : facing_q == DIR_UP ? 6 : 9) +
               (phase == M1 ? 0 : phase == M2 ? 2 : 1)) * SPR_W);
    rom.map_addr = 17'(my * 20'(MAP_W) + mx);
    rom.spr_addr = in_box ? 17'(sy * 20'(SHEET_W) + sx + col) : '0;
    pix_idx = in_box_q && rom.spr_idx != 5'(KEY_IDX) ? rom.spr_idx : rom.map_idx;
  end
  // align in_box with ROM data, then register the palette colour
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_box_q <= 1'b0;
      {Red, Green, Blue} <= '0;
    end else begin
      in_box_q <= in_box;
      {Red, Green, Blue} <= pix_idx < 5'(PALETTE_N) ? PALETTE[pix_idx] : 24'd0;
    end
  end
endmodule
